// File: rtl/aes_ctrl_pkg.sv
// Shared constants and helpers for the AES-256 ECB stream controller.
package aes_ctrl_pkg;

    localparam int BLOCK_W = 128;
    localparam int ENTRY_W = BLOCK_W + 1;   // {last, block}

    function automatic int credit_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/aes_ecb_stream_ctrl_fifo.sv
// Synchronous FIFO with registered full/empty; push and pop may coincide.
module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic             do_push, do_pop;

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        cnt_d = cnt_q;
        if (do_push && !do_pop)
            cnt_d = cnt_q + 1'b1;
        else if (!do_push && do_pop)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (do_push) wr_q <= wr_q + 1'b1;
            if (do_pop)  rd_q <= rd_q + 1'b1;
            cnt_q   <= cnt_d;
            full_q  <= (cnt_d == (AW+1)'(DEPTH));
            empty_q <= (cnt_d == '0);
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q] <= data_i;
    end

    // Zero when empty so consumers see a clean bus after reset.
    assign data_o  = empty_q ? '0 : mem_q[rd_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/aes_ecb_stream_ctrl.sv
// Schedules plaintext blocks into the AES core and collects ciphertext in order,
// bounding in-flight plus stored blocks by the output FIFO depth.
module aes_ecb_stream_ctrl
    import aes_ctrl_pkg::*;
#(
    parameter int IN_DEPTH  = 4,
    parameter int OUT_DEPTH = 8
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            enable_i,
    input  logic                            s_valid_i,
    output logic                            s_ready_o,
    input  logic [BLOCK_W-1:0]              s_data_i,
    input  logic                            s_last_i,
    output logic                            m_valid_o,
    input  logic                            m_ready_i,
    output logic [BLOCK_W-1:0]              m_data_o,
    output logic                            m_last_o,
    output logic                            core_enable_o,
    output logic                            core_start_o,
    output logic [BLOCK_W-1:0]              core_bytes_o,
    input  logic                            core_busy_i,
    input  logic [BLOCK_W-1:0]              core_bytes_i,
    input  logic                            core_valid_i,
    output logic [credit_w(OUT_DEPTH)-1:0]  inflight_o,
    output logic                            idle_o,
    output logic                            err_o
);

    localparam int CW = credit_w(OUT_DEPTH);

    logic               in_full, in_empty, tag_full, tag_empty, out_full, out_empty;
    logic [ENTRY_W-1:0] in_data, out_data;
    logic               tag_last;
    logic               issue, ret_ok, out_pop;

    logic               ready_q, start_q, en_q, err_q;
    logic [BLOCK_W-1:0] bytes_q;
    logic [CW-1:0]      inflight_q, inflight_d;
    logic [CW-1:0]      used_q, used_d;     // in flight plus stored in the output FIFO

    assign s_ready_o = ready_q && !in_full;
    assign out_pop   = !out_empty && m_ready_i;
    assign ret_ok    = core_valid_i && (inflight_q != '0);

    // Tag/output full terms are redundant with the credit check but keep it airtight.
    assign issue = enable_i && !core_busy_i && !in_empty && !tag_full && !out_full
                   && (used_q < CW'(OUT_DEPTH));

    always_comb begin
        inflight_d = inflight_q;
        if (issue && !ret_ok)
            inflight_d = inflight_q + 1'b1;
        else if (!issue && ret_ok)
            inflight_d = inflight_q - 1'b1;
        used_d = used_q;
        if (issue && !out_pop)
            used_d = used_q + 1'b1;
        else if (!issue && out_pop)
            used_d = used_q - 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q    <= 1'b0;
            start_q    <= 1'b0;
            bytes_q    <= '0;
            en_q       <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= '0;
            used_q     <= '0;
        end else begin
            ready_q    <= 1'b1;
            start_q    <= issue;
            if (issue) bytes_q <= in_data[BLOCK_W-1:0];
            en_q       <= enable_i || (inflight_d != '0);
            err_q      <= err_q || (core_valid_i && (inflight_q == '0));
            inflight_q <= inflight_d;
            used_q     <= used_d;
        end
    end

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(IN_DEPTH)) u_in_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (s_valid_i && s_ready_o),
        .data_i  ({s_last_i, s_data_i}),
        .pop_i   (issue),
        .data_o  (in_data),
        .full_o  (in_full),
        .empty_o (in_empty)
    );

    sync_fifo #(.WIDTH(1), .DEPTH(OUT_DEPTH)) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (issue),
        .data_i  (in_data[BLOCK_W]),
        .pop_i   (ret_ok),
        .data_o  (tag_last),
        .full_o  (tag_full),
        .empty_o (tag_empty)
    );

    sync_fifo #(.WIDTH(ENTRY_W), .DEPTH(OUT_DEPTH)) u_out_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (ret_ok),
        .data_i  ({tag_last, core_bytes_i}),
        .pop_i   (out_pop),
        .data_o  (out_data),
        .full_o  (out_full),
        .empty_o (out_empty)
    );

    assign m_valid_o              = !out_empty;
    assign {m_last_o, m_data_o}   = out_data;
    assign core_start_o           = start_q;
    assign core_bytes_o           = bytes_q;
    assign core_enable_o          = en_q;
    assign inflight_o             = inflight_q;
    assign err_o                  = err_q;
    assign idle_o                 = in_empty && tag_empty && out_empty && (inflight_q == '0);

endmodule

// File: tb/tb_aes_ecb_stream_ctrl.sv
// Directed scenarios with random data; a queue-based reference and a core model
// check ordering, credits, handshakes and error/reset behaviour every cycle.
module tb_aes_ecb_stream_ctrl;
    import aes_ctrl_pkg::*;

    localparam int IN_D  = 4;
    localparam int OUT_D = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_i = 1'b1, enable_i = 1'b0;
    logic               s_valid_i = 1'b0, s_last_i = 1'b0, m_ready_i = 1'b0;
    logic               core_busy_i = 1'b0, core_valid_i = 1'b0;
    logic [BLOCK_W-1:0] s_data_i = '0, core_bytes_i = '0;
    logic               s_ready_o, m_valid_o, m_last_o, core_enable_o, core_start_o, idle_o, err_o;
    logic [BLOCK_W-1:0] m_data_o, core_bytes_o;
    logic [3:0]         inflight_o;

    aes_ecb_stream_ctrl #(.IN_DEPTH(IN_D), .OUT_DEPTH(OUT_D)) dut (
        .clk_i(clk), .rst_i(rst_i), .enable_i(enable_i),
        .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .s_data_i(s_data_i), .s_last_i(s_last_i),
        .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o), .m_last_o(m_last_o),
        .core_enable_o(core_enable_o), .core_start_o(core_start_o), .core_bytes_o(core_bytes_o),
        .core_busy_i(core_busy_i), .core_bytes_i(core_bytes_i), .core_valid_i(core_valid_i),
        .inflight_o(inflight_o), .idle_o(idle_o), .err_o(err_o)
    );

    typedef struct { logic [127:0] d; int due; } core_t;

    core_t        cq[$];
    logic [128:0] src_q[$], exp_q[$];
    logic [127:0] iss_q[$];

    int checks = 0, errors = 0, cyc = 0, lat = 20;
    int acc_done = 0, starts = 0, returns = 0, cons_done = 0;
    bit acc_pend, ret_pend, cons_pend, inj_pend, inject, err_model, hold_pend;
    bit run_en, force_busy, sink_rdy, sink_rand;
    logic [128:0] hold_val;

    function automatic logic [127:0] cipher(input logic [127:0] x);
        return {x[63:0], x[127:64]} ^ 128'h0123_4567_89ab_cdef_fedc_ba98_7654_3210;
    endfunction

    function automatic logic [127:0] rnd_blk();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [128:0] got, input logic [128:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic drain(input string tag, input int maxc);
        bit ok = 0;
        for (int k = 0; k < maxc && !ok; k++) begin
            step(1);
            ok = (src_q.size() == 0) && (exp_q.size() == 0) && (cq.size() == 0) && idle_o;
        end
        chk({tag, "_drain"}, 129'(ok), 129'(1));
    endtask

    // Core model, source, sink and per-cycle reference checks, all just after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_i) begin
            cq.delete(); src_q.delete(); exp_q.delete(); iss_q.delete();
            acc_done = 0; starts = 0; returns = 0; cons_done = 0;
            acc_pend = 0; ret_pend = 0; cons_pend = 0; inj_pend = 0; inject = 0;
            err_model = 0; hold_pend = 0;
            enable_i = 0; s_valid_i = 0; m_ready_i = 0; core_valid_i = 0; core_busy_i = 0;
        end else begin
            if (acc_pend)  acc_done++;
            if (ret_pend)  returns++;
            if (cons_pend) cons_done++;
            if (inj_pend)  err_model = 1;
            acc_pend = 0; ret_pend = 0; cons_pend = 0; inj_pend = 0;

            if (core_start_o) begin
                starts++;
                chk("start_gate", 129'({core_busy_i, enable_i}), 129'(2'b01));
                chk("start_has_block", 129'(iss_q.size() != 0), 129'(1));
                if (iss_q.size() != 0) chk("core_bytes", 129'(core_bytes_o), 129'(iss_q.pop_front()));
                cq.push_back('{d: cipher(core_bytes_o), due: cyc + lat});
            end
            chk("inflight", 129'(inflight_o), 129'(starts - returns));
            chk("m_valid", 129'(m_valid_o), 129'(returns != cons_done));
            chk("idle", 129'(idle_o), 129'(acc_done == starts && starts == returns && returns == cons_done));
            chk("s_ready", 129'(s_ready_o), 129'((acc_done - starts) < IN_D));
            chk("credit", 129'((starts - cons_done) <= OUT_D), 129'(1));
            chk("err", 129'(err_o), 129'(err_model));
            chk("core_en", 129'(core_enable_o), 129'(enable_i || (starts != returns)));
            if (hold_pend) chk("hold", {m_last_o, m_data_o}, hold_val);

            enable_i    = run_en;
            core_busy_i = force_busy;
            m_ready_i   = sink_rand ? 1'($urandom_range(0, 1)) : sink_rdy;
            hold_pend   = m_valid_o && !m_ready_i;
            hold_val    = {m_last_o, m_data_o};
            if (m_valid_o && m_ready_i) begin
                chk("out_avail", 129'(exp_q.size() != 0), 129'(1));
                if (exp_q.size() != 0) chk("out_data", {m_last_o, m_data_o}, exp_q.pop_front());
                cons_pend = 1;
            end

            if (inject) begin
                core_valid_i = 1; core_bytes_i = rnd_blk(); inject = 0; inj_pend = 1;
            end else if (cq.size() != 0 && cq[0].due <= cyc) begin
                core_valid_i = 1; core_bytes_i = cq[0].d; void'(cq.pop_front()); ret_pend = 1;
            end else begin
                core_valid_i = 0;
            end

            if (src_q.size() != 0) begin
                s_valid_i = 1;
                {s_last_i, s_data_i} = src_q[0];
                if (s_ready_o) begin
                    exp_q.push_back({src_q[0][128], cipher(src_q[0][127:0])});
                    iss_q.push_back(src_q[0][127:0]);
                    void'(src_q.pop_front());
                    acc_pend = 1;
                end
            end else begin
                s_valid_i = 0;
            end
            cyc++;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_s, base_c;
        bit ok;
        logic [127:0] blk;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 129'(s_ready_o), 129'(0));
        chk("rst_m_valid", 129'(m_valid_o), 129'(0));
        chk("rst_m_data", 129'({m_last_o, m_data_o}), 129'(0));
        chk("rst_start", 129'(core_start_o), 129'(0));
        chk("rst_bytes", 129'(core_bytes_o), 129'(0));
        chk("rst_core_en", 129'(core_enable_o), 129'(0));
        chk("rst_inflight", 129'(inflight_o), 129'(0));
        chk("rst_idle", 129'(idle_o), 129'(1));
        chk("rst_err", 129'(err_o), 129'(0));
        rst_i = 0; run_en = 1; sink_rdy = 1;
        step(2);
        chk("post_rst_s_ready", 129'(s_ready_o), 129'(1));

        // Eight counting-pattern blocks, last on the eighth, latency 20
        lat = 20; base_s = starts; base_c = cons_done;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 16; j++) blk[8*j +: 8] = 8'(i*16 + j);
            src_q.push_back({(i == 7), blk});
        end
        drain("t1", 400);
        chk("t1_starts", 129'(starts - base_s), 129'(8));
        chk("t1_outs", 129'(cons_done - base_c), 129'(8));
        chk("t1_idle", 129'(idle_o), 129'(1));

        // Sink stalled: issue stops at the credit limit, input FIFO fills
        sink_rdy = 0; lat = 5; base_s = starts; base_c = cons_done;
        for (int i = 0; i < 12; i++) src_q.push_back({1'($urandom_range(0, 1)), rnd_blk()});
        step(80);
        chk("t2_issued", 129'(starts - base_s), 129'(8));
        chk("t2_s_ready", 129'(s_ready_o), 129'(0));
        chk("t2_offered", 129'(src_q.size()), 129'(0));
        chk("t2_inflight", 129'(inflight_o), 129'(0));
        sink_rdy = 1;
        drain("t2", 300);
        chk("t2_outs", 129'(cons_done - base_c), 129'(12));

        // Core busy for 10 cycles mid-stream
        lat = 3; base_s = starts; base_c = cons_done;
        for (int i = 0; i < 16; i++) src_q.push_back({(i == 15), rnd_blk()});
        ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin step(1); ok = (starts - base_s) >= 5; end
        chk("t3_reach5", 129'(ok), 129'(1));
        force_busy = 1;
        step(10);
        force_busy = 0;
        step(2);
        chk("t3_resume", 129'(core_start_o), 129'(1));
        sink_rand = 1;
        drain("t3", 400);
        chk("t3_outs", 129'(cons_done - base_c), 129'(16));
        sink_rand = 0;

        // enable_i dropped after three issues with two results pending
        lat = 6; base_s = starts; base_c = cons_done;
        src_q.push_back({1'b0, rnd_blk()});
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin step(1); ok = (starts - base_s) == 1; end
        step(4);
        src_q.push_back({1'b0, rnd_blk()});
        src_q.push_back({1'b0, rnd_blk()});
        ok = 0;
        for (int k = 0; k < 40 && !ok; k++) begin
            step(1); ok = ((starts - base_s) == 3) && (inflight_o == 2);
        end
        chk("t4_two_pending", 129'(ok), 129'(1));
        run_en = 0;
        for (int i = 0; i < 3; i++) src_q.push_back({(i == 2), rnd_blk()});
        for (int k = 0; k < 40 && inflight_o != 0; k++) begin
            chk("t4_core_en_hold", 129'(core_enable_o), 129'(1));
            step(1);
        end
        step(5);
        chk("t4_inflight", 129'(inflight_o), 129'(0));
        chk("t4_no_issue", 129'(starts - base_s), 129'(3));
        chk("t4_delivered", 129'(cons_done - base_c), 129'(3));
        chk("t4_core_en_low", 129'(core_enable_o), 129'(0));
        run_en = 1;
        drain("t4", 200);
        chk("t4_outs", 129'(cons_done - base_c), 129'(6));

        // Spurious core result with nothing in flight
        chk("t5_idle", 129'(idle_o), 129'(1));
        inject = 1;
        step(2);
        chk("t5_err", 129'(err_o), 129'(1));
        chk("t5_m_valid", 129'(m_valid_o), 129'(0));
        chk("t5_inflight", 129'(inflight_o), 129'(0));
        step(5);
        chk("t5_err_sticky", 129'(err_o), 129'(1));

        // Reset with three in flight and two stored
        sink_rdy = 0; lat = 15; base_s = starts;
        src_q.push_back({1'b0, rnd_blk()});
        src_q.push_back({1'b0, rnd_blk()});
        ok = 0;
        for (int k = 0; k < 60 && !ok; k++) begin
            step(1); ok = ((starts - base_s) == 2) && (inflight_o == 0);
        end
        for (int i = 0; i < 3; i++) src_q.push_back({1'b0, rnd_blk()});
        ok = 0;
        for (int k = 0; k < 30 && !ok; k++) begin
            step(1); ok = ((starts - base_s) == 5) && (inflight_o == 3);
        end
        chk("t6_setup", 129'(ok && m_valid_o), 129'(1));
        @(negedge clk);
        rst_i = 1;
        @(posedge clk);
        @(negedge clk);
        chk("t6_m_valid", 129'(m_valid_o), 129'(0));
        chk("t6_inflight", 129'(inflight_o), 129'(0));
        chk("t6_idle", 129'(idle_o), 129'(1));
        chk("t6_err", 129'(err_o), 129'(0));
        chk("t6_s_ready", 129'(s_ready_o), 129'(0));
        rst_i = 0; sink_rdy = 1; lat = 4;
        step(1);
        src_q.push_back({1'b1, rnd_blk()});
        drain("t6", 100);
        chk("t6_fresh", 129'(cons_done), 129'(1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
